// File: rtl/histogram.sv
// Gray-level histogram: BINS saturating counters held in block RAM.
// A two-stage read-modify-write pipeline sustains one increment per cycle.
// A single forwarding register covers the one read/write collision the
// pipeline can produce, which is a read and a write of the same bin on the
// same edge. Clear sweeps go through the same write stage as increments so
// that all writes land in the order they were accepted.
module histogram #(
  parameter int BINS = 256,
  parameter int CW   = 20
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iClear,
  input  logic          iInc,
  input  logic [7:0]    iGray,
  output logic [7:0]    oGray,
  output logic [CW-1:0] oGrayHisto
);

  localparam int AW = (BINS > 1) ? $clog2(BINS) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [AW-1:0] LAST_BIN = AW'(BINS - 1);

  // Bin storage with registered read data.
  logic [CW-1:0] mem [BINS];
  logic [CW-1:0] rd_data_reg;

  // Second pipeline stage: the request captured on the previous edge.
  logic [7:0]    gray_reg;
  logic          inc_reg;
  logic          clr_reg;
  logic [AW-1:0] clr_waddr_reg;
  logic          zero_reg;

  // Clear sweep pointer.
  logic [AW-1:0] clr_addr_reg;

  // The write that landed on the previous edge, for forwarding.
  logic          wr_valid_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [CW-1:0] wr_data_reg;

  // Combinational write-stage signals.
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] stage_addr;
  logic          fwd_hit;
  logic [CW-1:0] count_cur;
  logic [CW-1:0] count_next;
  logic          we;
  logic [AW-1:0] waddr;
  logic [CW-1:0] wdata;

  assign rd_addr    = iGray[AW-1:0];
  assign stage_addr = gray_reg[AW-1:0];

  // A read issued on the same edge as a write to that bin returns stale data;
  // the value just written is substituted in that case.
  assign fwd_hit    = wr_valid_reg && (wr_addr_reg == stage_addr);
  assign count_cur  = fwd_hit ? wr_data_reg : rd_data_reg;
  assign count_next = (count_cur == CNT_MAX) ? count_cur : count_cur + CW'(1);

  // A reset edge drops whatever is sitting in the write stage.
  assign we    = iRst_n && (inc_reg || clr_reg);
  assign waddr = clr_reg ? clr_waddr_reg : stage_addr;
  assign wdata = clr_reg ? '0 : count_next;

  assign oGray      = gray_reg;
  assign oGrayHisto = zero_reg ? '0 : count_cur;

  // Bin memory: one write and one registered read per cycle, no reset.
  always_ff @(posedge iClk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data_reg <= mem[rd_addr];
  end

  // Request pipeline, clear sweep pointer and forwarding register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      gray_reg      <= '0;
      inc_reg       <= 1'b0;
      clr_reg       <= 1'b0;
      clr_waddr_reg <= '0;
      zero_reg      <= 1'b1;
      clr_addr_reg  <= '0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      gray_reg      <= iGray;
      inc_reg       <= iInc && !iClear;
      clr_reg       <= iClear;
      clr_waddr_reg <= clr_addr_reg;
      zero_reg      <= iClear;
      if (iClear) begin
        clr_addr_reg <= (clr_addr_reg == LAST_BIN) ? '0 : clr_addr_reg + AW'(1);
      end else begin
        clr_addr_reg <= '0;
      end
      wr_valid_reg  <= we;
      wr_addr_reg   <= waddr;
      wr_data_reg   <= wdata;
    end
  end

endmodule

// File: tb/tb_histogram.sv
// Bench for histogram: a 20-bit and a 4-bit build driven with identical
// stimulus, checked against a per-bin count model plus literal vectors.
module tb_histogram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        inc;
  logic [7:0]  gray;
  logic [7:0]  o_gray_w;
  logic [7:0]  o_gray_n;
  logic [19:0] histo_w;
  logic [3:0]  histo_n;

  always #5 clk = ~clk;

  histogram #(.BINS(256), .CW(20)) dut_wide (
    .iClk(clk), .iRst_n(rst_n), .iClear(clear), .iInc(inc), .iGray(gray),
    .oGray(o_gray_w), .oGrayHisto(histo_w)
  );

  histogram #(.BINS(256), .CW(4)) dut_narrow (
    .iClk(clk), .iRst_n(rst_n), .iClear(clear), .iInc(inc), .iGray(gray),
    .oGray(o_gray_n), .oGrayHisto(histo_n)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: unbounded count per bin, whether the bin has been cleared
  // since power-up, and the clear sweep position.
  int cnt   [256];
  bit known [256];
  int clr_ptr = 0;

  typedef struct {
    bit         r;
    bit         c;
    bit         i;
    logic [7:0] g;
    int         e_gray;
    int         e_histo;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  // One cycle: drive inputs, clock, compare outputs with the model, advance model.
  task automatic step(input bit r, input bit c, input bit i, input logic [7:0] g);
    int e_gray;
    int raw;
    bit have;
    rst_n  = r;
    clear  = c;
    inc    = i;
    gray   = g;
    e_gray = r ? int'(g) : 0;
    have   = !r || c || known[g];
    raw    = (!r || c) ? 0 : cnt[g];
    @(posedge clk);
    #1;
    if (r) begin
      if (c) begin
        cnt[clr_ptr]   = 0;
        known[clr_ptr] = 1'b1;
        clr_ptr        = (clr_ptr + 1) % 256;
      end else begin
        clr_ptr = 0;
        if (i) cnt[g]++;
      end
    end else begin
      clr_ptr = 0;
    end
    check("ogray_w", int'(o_gray_w), e_gray);
    check("ogray_n", int'(o_gray_n), e_gray);
    if (have) begin
      check("histo_w", int'(histo_w), sat(raw, 20));
      check("histo_n", int'(histo_n), sat(raw, 4));
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      cnt[k]   = 0;
      known[k] = 1'b0;
    end
    rst_n = 1'b0;
    clear = 1'b0;
    inc   = 1'b0;
    gray  = 8'd0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 8'd33);
    check("rst_ogray", int'(o_gray_w), 0);
    check("rst_histo", int'(histo_w), 0);

    // Full clear sweep with increments requested throughout (ignored).
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'(k));
      check("clr_histo", int'(histo_w), 0);
      check("clr_ogray", int'(o_gray_w), k);
    end

    // Hazard patterns, read-after-increment, reset retention, short clears.
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd7,   7,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd8,   8,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd7,   7,   1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd7,   7,   2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd8,   8,   1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd7,   7,   3});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd7,   7,   4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd8,   8,   2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd9,   9,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd9,   9,   1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd7,   7,   4});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 8'd7,   0,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd7,   7,   4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd8,   8,   2});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 8'd200, 200, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 8'd1,   1,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd200, 200, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd1,   1,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd7,   7,   4});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 8'd9,   9,   1});
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].r, tbl[k].c, tbl[k].i, tbl[k].g);
      check($sformatf("tbl%0d_ogray", k), int'(o_gray_w), tbl[k].e_gray);
      check($sformatf("tbl%0d_histo", k), int'(histo_w), tbl[k].e_histo);
    end

    // Same-bin streaming.
    for (int k = 0; k < 1000; k++) step(1'b1, 1'b0, 1'b1, 8'd5);
    step(1'b1, 1'b0, 1'b0, 8'd5);
    check("stream_bin5_w", int'(histo_w), 1000);
    check("stream_bin5_n", int'(histo_n), 15);
    step(1'b1, 1'b0, 1'b0, 8'd4);
    check("stream_bin4", int'(histo_w), 0);
    step(1'b1, 1'b0, 1'b0, 8'd6);
    check("stream_bin6", int'(histo_w), 0);

    // Saturation of the 4-bit build.
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, 1'b1, 8'd3);
    step(1'b1, 1'b0, 1'b0, 8'd3);
    check("sat_bin3_n", int'(histo_n), 15);
    check("sat_bin3_w", int'(histo_w), 20);

    // Randomized traffic with clear bursts and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 2) begin
        step(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
      end else if (sel < 5) begin
        int len;
        len = ($urandom_range(0, 3) == 0) ? 256 + int'($urandom_range(0, 20))
                                          : int'($urandom_range(1, 40));
        for (int k = 0; k < len; k++) begin
          step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end
      end else begin
        logic [7:0] g;
        g = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7))
                                        : 8'($urandom_range(0, 255));
        step(1'b1, 1'b0, ($urandom_range(0, 9) < 7), g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/histogram.md
HISTOGRAM -- requirements
Module: histogram

Interface
REQ-001 SHALL have parameter BINS, default 256: number of bins, one per 8-bit gray level.
REQ-002 SHALL have parameter CW, default 20: count width, which covers an 800x480 frame (384000 pixels).
REQ-003 iClk  input  1  sole clock; all state updates on the rising edge.
REQ-004 iRst_n  input  1  reset, synchronous and active-low.
REQ-005 iClear  input  1  while high, sweep-clears all bins to zero.
REQ-006 iInc  input  1  when high, increments the bin addressed by iGray.
REQ-007 iGray  input  8  gray level; used as the increment address and as the read address.
REQ-008 oGray  output  8  iGray registered one cycle, aligned with oGrayHisto.
REQ-009 oGrayHisto  output  CW  count of bin iGray from the previous cycle.

Function
REQ-010 SHALL store 256 counters of CW bits each in internal memory (block-RAM style, one read and one write per cycle).
REQ-011 SHALL, while iClear=1, write zero to bin clr_addr on each edge and increment clr_addr by 1 modulo 256.
- 256 consecutive iClear-high cycles zero every bin.
REQ-012 SHALL reset clr_addr to 0 on the first cycle iClear=0, so every clear burst starts at bin 0.
REQ-013 SHALL ignore iInc while iClear=1: no bin is incremented.
REQ-014 SHALL, when iInc=1 and iClear=0, add 1 to bin iGray via an internal read-modify-write pipeline.
REQ-015 SHALL sustain one increment per cycle with no lost counts, including:
- back-to-back increments of the same bin;
- A,B,A patterns.
This requires write-to-read forwarding of every in-flight increment.
REQ-016 SHALL saturate a bin at 2^CW-1; an increment of a full bin leaves it unchanged (no wrap to 0).
REQ-017 SHALL register iGray to oGray every cycle (1-cycle latency), independent of iInc and iClear.
REQ-018 SHALL drive oGrayHisto, one cycle after iGray=g is presented, with the count of bin g including every increment accepted on earlier cycles.
- An increment of g in the same cycle as the read is excluded.
- Forwarding applies here as well.
REQ-019 SHALL drive oGrayHisto=0 on the cycle following any cycle with iClear=1.
REQ-020 SHALL have no input handshake: every cycle's iInc/iGray is consumed, and there is no busy or ready output.

Reset
REQ-021 SHALL, on an edge with iRst_n=0, set oGray=0, oGrayHisto=0 and clr_addr=0, and flush all pending increments in the pipeline.
REQ-022 SHALL NOT clear the bin memory on reset; bin contents are undefined after power-up until a 256-cycle iClear sweep completes.
REQ-023 SHALL give iRst_n priority over iClear and iInc; an increment presented on a reset cycle is dropped.
REQ-024 SHALL, if iClear deasserts before 256 cycles, leave uncleared bins holding their prior values.

Verification
REQ-025 Full clear: iClear=1 for 256 cycles, then read all g=0..255 -> oGrayHisto=0 for every g, and oGray=g one cycle after each read.
REQ-026 Same-bin streaming: after a clear, iInc=1 with iGray=5 for 1000 consecutive cycles, then read g=5 -> 1000; reading g=4 and g=6 -> 0.
REQ-027 Interleaved hazards: after a clear, iGray sequence 7,8,7,7,8,7 with iInc=1, then read -> bin7=4, bin8=2.
REQ-028 Read-after-increment: increment bin 9 once, then present iGray=9 with iInc=0 on the very next cycle -> oGrayHisto=1 one cycle later.
REQ-029 Saturation (CW=4 build): increment bin 3 twenty times -> reads 15.
REQ-030 Clear and reset interaction:
- iInc=1 during iClear -> bins stay 0;
- iRst_n=0 for one cycle mid-stream -> outputs 0 next cycle, and bin values from before reset are retained.
